// File: rtl/line_burst_pkg.sv
// -----------------------------------------------------------------------------
// line_burst_pkg
// Shared types and constants for the cache-line burst responder.
//   LINE_OFFSET_BITS : byte-offset bits inside a 32-byte line (cleared on accept)
//   BEATS            : beats per line at the default 256/64 geometry
//   BEAT_IDX_BITS    : width of a beat index at the default geometry
//   beat_idx_t       : beat index type at the default geometry
//   burst_state_t    : responder FSM states
// -----------------------------------------------------------------------------
package line_burst_pkg;

  localparam int LINE_OFFSET_BITS = 5;
  localparam int BEATS            = 4;
  localparam int BEAT_IDX_BITS    = $clog2(BEATS);

  typedef logic [BEAT_IDX_BITS-1:0] beat_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } burst_state_t;

endpackage

// File: rtl/line_burst_responder_if.sv
// -----------------------------------------------------------------------------
// line_burst_responder_if
// Line-wide request/response port between the L1 arbiter (master) and the
// burst responder (slave).
//   line_read/line_write : request strobes, held by the master until line_resp
//   line_address         : byte address of the line
//   line_wdata           : line to write
//   line_resp            : one-cycle completion pulse from the slave
//   line_rdata           : read line, valid with line_resp and held afterwards
// -----------------------------------------------------------------------------
interface line_burst_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);

  logic                  line_read;
  logic                  line_write;
  logic [ADDR_WIDTH-1:0] line_address;
  logic [LINE_WIDTH-1:0] line_wdata;
  logic                  line_resp;
  logic [LINE_WIDTH-1:0] line_rdata;

  modport master (
    output line_read,
    output line_write,
    output line_address,
    output line_wdata,
    input  line_resp,
    input  line_rdata
  );

  modport slave (
    input  line_read,
    input  line_write,
    input  line_address,
    input  line_wdata,
    output line_resp,
    output line_rdata
  );

endinterface

// File: rtl/line_burst_responder_beat_buffer.sv
// -----------------------------------------------------------------------------
// line_beat_buffer
// BEATS x BEAT_WIDTH register array holding one cache line as beats.
//   clk, rst   : clock, synchronous active-high reset (clears all beats)
//   load       : capture the whole line from load_data (has priority)
//   load_data  : flat line, beat 0 in the least significant bits
//   wr_en      : write wr_data into beat wr_idx
//   rd_idx     : beat selected onto rd_data
//   rd_data    : registered beat at rd_idx
//   line_out   : whole buffer as a flat line, beat 0 in the LSBs
// -----------------------------------------------------------------------------
module line_beat_buffer #(
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = 4,
  parameter int IDX_W      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [BEATS*BEAT_WIDTH-1:0] load_data,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic [BEAT_WIDTH-1:0]       wr_data,
  input  logic [IDX_W-1:0]            rd_idx,
  output logic [BEAT_WIDTH-1:0]       rd_data,
  output logic [BEATS*BEAT_WIDTH-1:0] line_out
);

  logic [BEAT_WIDTH-1:0] beats_q [BEATS];
  logic [BEAT_WIDTH-1:0] beats_d [BEATS];

  always_comb begin
    for (int i = 0; i < BEATS; i++) begin
      beats_d[i] = beats_q[i];
      if (load) begin
        beats_d[i] = load_data[i*BEAT_WIDTH +: BEAT_WIDTH];
      end else if (wr_en && (wr_idx == IDX_W'(i))) begin
        beats_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BEATS; i++) beats_q[i] <= '0;
    end else begin
      for (int i = 0; i < BEATS; i++) beats_q[i] <= beats_d[i];
    end
  end

  assign rd_data = beats_q[rd_idx];

  for (genvar g = 0; g < BEATS; g++) begin : g_flat
    assign line_out[g*BEAT_WIDTH +: BEAT_WIDTH] = beats_q[g];
  end

endmodule

// File: rtl/line_burst_responder.sv
// -----------------------------------------------------------------------------
// line_burst_responder
// Turns each single-transfer cache-line request into a BEATS-beat burst on the
// memory side and answers with a one-cycle line_resp.
//   clk, rst     : clock, synchronous active-high reset
//   line_if      : line-side request port (slave modport)
//   mem_read     : burst read request, high for the whole read burst
//   mem_write    : burst write request, high for the whole write burst
//   mem_address  : line-aligned burst address
//   mem_wdata    : current write beat (zero outside a write burst)
//   mem_resp     : per-beat acknowledge, one beat per high cycle
//   mem_rdata    : read beat, valid with mem_resp
// -----------------------------------------------------------------------------
module line_burst_responder
  import line_burst_pkg::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  line_burst_responder_if.slave line_if,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BEAT_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp,
  input  logic [BEAT_WIDTH-1:0] mem_rdata
);

  localparam int NBEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDX_W-1:0]      LAST_BEAT   = IDX_W'(NBEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << LINE_OFFSET_BITS) - 1);

  burst_state_t          state_q, state_d;
  logic [IDX_W-1:0]      beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

  logic                  wbuf_load;
  logic                  rbuf_wr;
  logic [LINE_WIDTH-1:0] rbuf_line;
  logic [BEAT_WIDTH-1:0] wbuf_beat;

  line_beat_buffer #(
    .BEAT_WIDTH (BEAT_WIDTH),
    .BEATS      (NBEATS),
    .IDX_W      (IDX_W)
  ) u_rbuf (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .wr_en     (rbuf_wr),
    .wr_idx    (beat_q),
    .wr_data   (mem_rdata),
    .rd_idx    (beat_q),
    .rd_data   (),
    .line_out  (rbuf_line)
  );

  line_beat_buffer #(
    .BEAT_WIDTH (BEAT_WIDTH),
    .BEATS      (NBEATS),
    .IDX_W      (IDX_W)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .load      (wbuf_load),
    .load_data (line_if.line_wdata),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .rd_idx    (beat_q),
    .rd_data   (wbuf_beat),
    .line_out  ()
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    wbuf_load = 1'b0;
    rbuf_wr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Read has priority; a simultaneous write is dropped, not latched.
        if (line_if.line_read) begin
          addr_d  = line_if.line_address & ~OFFSET_MASK;
          beat_d  = '0;
          state_d = RD_BURST;
        end else if (line_if.line_write) begin
          addr_d    = line_if.line_address & ~OFFSET_MASK;
          beat_d    = '0;
          wbuf_load = 1'b1;
          state_d   = WR_BURST;
        end
      end
      RD_BURST: begin
        if (mem_resp) begin
          rbuf_wr = 1'b1;
          beat_d  = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = RD_DONE;
        end
      end
      RD_DONE: begin
        // Keep the completed line so line_rdata survives the next read burst.
        rdata_d = rbuf_line;
        state_d = IDLE;
      end
      WR_BURST: begin
        if (mem_resp) begin
          beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = WR_DONE;
        end
      end
      WR_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign line_if.line_resp  = (state_q == RD_DONE) || (state_q == WR_DONE);
  // In RD_DONE the holding register is not loaded yet, so expose the buffer.
  assign line_if.line_rdata = (state_q == RD_DONE) ? rbuf_line : rdata_q;
  assign mem_read           = (state_q == RD_BURST);
  assign mem_write          = (state_q == WR_BURST);
  assign mem_address        = addr_q;
  assign mem_wdata          = (state_q == WR_BURST) ? wbuf_beat : '0;

endmodule
